// File: rtl/pipe_pkg.sv
// Pipeline-wide definitions: redirect FSM states and field positions in the 8-bit ctrl word.
package pipe_pkg;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } redirect_state_e;

   // ctrl word layout: {wreg, mem_read, mem_write, rd_addr[4:0]}
   localparam int CTRL_W         = 8;
   localparam int CTRL_WREG      = 7;
   localparam int CTRL_MEM_READ  = 6;
   localparam int CTRL_MEM_WRITE = 5;
   localparam int CTRL_RD_MSB    = 4;
   localparam int CTRL_RD_LSB    = 0;

endpackage : pipe_pkg

// File: rtl/port_define.sv
// Shared datapath widths for the pipeline: register bus and instruction address bus.
package port_define;

   localparam int REG_BUS_W       = 32;
   localparam int INST_ADDR_BUS_W = 32;

   typedef logic [REG_BUS_W-1:0]       reg_bus_t;
   typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_bus_t;

endpackage : port_define

// File: rtl/ex_mem_stage_if.sv
// EX-side payload into the EX/MEM register and the registered MEM-side payload out of it.
interface ex_mem_stage_if;
   import port_define::*;
   import pipe_pkg::*;

   logic                ex_valid_i;
   reg_bus_t            ex_alu_result_i;
   logic                ex_overflow_i;
   logic                ex_branch_true_i;
   inst_addr_bus_t      ex_new_addr_i;
   logic [CTRL_W-1:0]   ex_ctrl_i;
   reg_bus_t            ex_store_data_i;

   logic                mem_valid_o;
   reg_bus_t            mem_alu_result_o;
   logic [CTRL_W-1:0]   mem_ctrl_o;
   reg_bus_t            mem_store_data_o;

   // master: EX producer / MEM consumer side; slave: the pipeline stage itself
   modport master (
      output ex_valid_i, ex_alu_result_i, ex_overflow_i, ex_branch_true_i,
             ex_new_addr_i, ex_ctrl_i, ex_store_data_i,
      input  mem_valid_o, mem_alu_result_o, mem_ctrl_o, mem_store_data_o
   );

   modport slave (
      input  ex_valid_i, ex_alu_result_i, ex_overflow_i, ex_branch_true_i,
             ex_new_addr_i, ex_ctrl_i, ex_store_data_i,
      output mem_valid_o, mem_alu_result_o, mem_ctrl_o, mem_store_data_o
   );

endinterface : ex_mem_stage_if

// File: rtl/branch_redirect_ctrl.sv
// Two-state redirect FSM: a taken branch raises redirect/flush until the stall drops,
// and squashes wrong-path EX instructions while doing so.
module branch_redirect_ctrl
   import pipe_pkg::*;
   import port_define::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           accept_i,
   input  logic           branch_i,
   input  inst_addr_bus_t target_i,
   input  logic           stall_i,
   output logic           redirect_valid_o,
   output inst_addr_bus_t redirect_addr_o,
   output logic           flush_o,
   output logic           squash_o
);

   redirect_state_e r_state;
   logic            r_redirect;
   inst_addr_bus_t  r_redirect_addr;

   // NOTE: state is updated with non-blocking assignments so every register in this
   // block sees the pre-edge values; blocking here would create order-dependent logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_redirect      <= 1'b0;
         r_redirect_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (accept_i && branch_i) begin
                  r_state         <= ST_REDIRECT;
                  r_redirect      <= 1'b1;
                  r_redirect_addr <= target_i;
               end
            end
            ST_REDIRECT: begin
               if (!stall_i) begin
                  r_state    <= ST_IDLE;
                  r_redirect <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_redirect <= 1'b0;
            end
         endcase
      end
   end

   assign redirect_valid_o = r_redirect;
   assign flush_o          = r_redirect;
   assign redirect_addr_o  = r_redirect_addr;
   assign squash_o         = (r_state == ST_REDIRECT);

endmodule : branch_redirect_ctrl

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect control and a saturating overflow counter.
module ex_mem_stage
   import pipe_pkg::*;
   import port_define::*;
#(
   parameter int OV_CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall_i,
   input  logic                ov_clr_i,
   ex_mem_stage_if.slave       bus,
   output logic                redirect_valid_o,
   output inst_addr_bus_t      redirect_addr_o,
   output logic                flush_o,
   output logic                ov_sticky_o,
   output logic [OV_CNT_W-1:0] ov_count_o
);

   logic              w_squash;
   logic              w_accept;
   logic              w_ov_accept;

   logic              r_mem_valid;
   reg_bus_t          r_mem_alu_result;
   logic [CTRL_W-1:0] r_mem_ctrl;
   reg_bus_t          r_mem_store_data;
   logic              r_ov_sticky;
   logic [OV_CNT_W-1:0] r_ov_count;

   // Stale ALU flags are harmless because everything below is gated by w_accept.
   assign w_accept    = bus.ex_valid_i & ~stall_i & ~w_squash;
   assign w_ov_accept = w_accept & bus.ex_overflow_i;

   branch_redirect_ctrl u_redirect (
      .clk              (clk),
      .rst_n            (rst_n),
      .accept_i         (w_accept),
      .branch_i         (bus.ex_branch_true_i),
      .target_i         (bus.ex_new_addr_i),
      .stall_i          (stall_i),
      .redirect_valid_o (redirect_valid_o),
      .redirect_addr_o  (redirect_addr_o),
      .flush_o          (flush_o),
      .squash_o         (w_squash)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_valid      <= 1'b0;
         r_mem_alu_result <= '0;
         r_mem_ctrl       <= '0;
         r_mem_store_data <= '0;
      end else if (!stall_i) begin
         r_mem_valid <= w_accept;
         if (w_accept) begin
            r_mem_alu_result <= bus.ex_alu_result_i;
            r_mem_ctrl       <= bus.ex_ctrl_i;
            r_mem_store_data <= bus.ex_store_data_i;
         end else begin
            // Bubble: kill the side-effect flags so MEM/WB cannot act on a stale slot.
            r_mem_ctrl[CTRL_WREG]      <= 1'b0;
            r_mem_ctrl[CTRL_MEM_READ]  <= 1'b0;
            r_mem_ctrl[CTRL_MEM_WRITE] <= 1'b0;
         end
      end
   end

   // Clear wins over stall but not over a same-cycle overflow, which restarts at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ov_sticky <= 1'b0;
         r_ov_count  <= '0;
      end else if (ov_clr_i) begin
         r_ov_sticky <= w_ov_accept;
         r_ov_count  <= w_ov_accept ? OV_CNT_W'(1) : '0;
      end else if (w_ov_accept) begin
         r_ov_sticky <= 1'b1;
         if (r_ov_count != '1) begin
            r_ov_count <= r_ov_count + OV_CNT_W'(1);
         end
      end
   end

   assign bus.mem_valid_o      = r_mem_valid;
   assign bus.mem_alu_result_o = r_mem_alu_result;
   assign bus.mem_ctrl_o       = r_mem_ctrl;
   assign bus.mem_store_data_o = r_mem_store_data;
   assign ov_sticky_o          = r_ov_sticky;
   assign ov_count_o           = r_ov_count;

endmodule : ex_mem_stage

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: capture, bubbles, stalls, redirect,
// overflow saturation/clear and asynchronous reset.
module tb_ex_mem_stage;
   import port_define::*;

   logic           clk;
   logic           rst_n;
   logic           stall_i;
   logic           ov_clr_i;
   logic           redirect_valid_o;
   inst_addr_bus_t redirect_addr_o;
   logic           flush_o;
   logic           ov_sticky_o;
   logic [7:0]     ov_count_o;

   int tests_run    = 0;
   int tests_failed = 0;

   ex_mem_stage_if bus_if ();

   ex_mem_stage #(.OV_CNT_W(8)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_i          (stall_i),
      .ov_clr_i         (ov_clr_i),
      .bus              (bus_if),
      .redirect_valid_o (redirect_valid_o),
      .redirect_addr_o  (redirect_addr_o),
      .flush_o          (flush_o),
      .ov_sticky_o      (ov_sticky_o),
      .ov_count_o       (ov_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_ex(input logic v, input logic [31:0] res, input logic [7:0] ctrl,
                         input logic br, input logic [31:0] addr, input logic ovf);
      bus_if.ex_valid_i       = v;
      bus_if.ex_alu_result_i  = res;
      bus_if.ex_ctrl_i        = ctrl;
      bus_if.ex_branch_true_i = br;
      bus_if.ex_new_addr_i    = addr;
      bus_if.ex_overflow_i    = ovf;
      bus_if.ex_store_data_i  = ~res;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall_i = 1'b0; ov_clr_i = 1'b0;
      set_ex(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0);
      step();
      tests_run++;
      if ({bus_if.mem_valid_o, redirect_valid_o, flush_o, ov_sticky_o} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b exp 0000",
                  {bus_if.mem_valid_o, redirect_valid_o, flush_o, ov_sticky_o});
      end
      tests_run++;
      if ({bus_if.mem_alu_result_o, bus_if.mem_ctrl_o, bus_if.mem_store_data_o,
           redirect_addr_o, ov_count_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_payload: res %h ctrl %h st %h addr %h cnt %h exp all 0",
                  bus_if.mem_alu_result_o, bus_if.mem_ctrl_o, bus_if.mem_store_data_o,
                  redirect_addr_o, ov_count_o);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_alu_capture();
      set_ex(1'b1, 32'h0000_0005, 8'h83, 1'b0, 32'h0, 1'b0);
      step();
      tests_run++;
      if ({bus_if.mem_valid_o, bus_if.mem_alu_result_o, bus_if.mem_ctrl_o,
           bus_if.mem_store_data_o} !== {1'b1, 32'h5, 8'h83, 32'hFFFF_FFFA}) begin
         tests_failed++;
         $display("FAIL alu_capture: v %b res %h ctrl %h st %h exp 1 5 83 fffffffa",
                  bus_if.mem_valid_o, bus_if.mem_alu_result_o, bus_if.mem_ctrl_o,
                  bus_if.mem_store_data_o);
      end
      set_ex(1'b0, 32'h0, 8'hE0, 1'b0, 32'h0, 1'b0);
      step();
      tests_run++;
      if (bus_if.mem_valid_o !== 1'b0 || (bus_if.mem_ctrl_o & 8'hE0) !== 8'h00) begin
         tests_failed++;
         $display("FAIL bubble: v %b ctrl %h exp v 0 and flags 0",
                  bus_if.mem_valid_o, bus_if.mem_ctrl_o);
      end
   endtask

   task automatic test_stall_hold();
      set_ex(1'b1, 32'h0000_1234, 8'h45, 1'b0, 32'h0, 1'b0);
      step();
      stall_i = 1'b1;
      set_ex(1'b1, 32'h0000_9999, 8'hE1, 1'b0, 32'h0, 1'b0);
      step();
      step();
      tests_run++;
      if ({bus_if.mem_valid_o, bus_if.mem_alu_result_o, bus_if.mem_ctrl_o}
          !== {1'b1, 32'h1234, 8'h45}) begin
         tests_failed++;
         $display("FAIL stall_hold: v %b res %h ctrl %h exp 1 1234 45",
                  bus_if.mem_valid_o, bus_if.mem_alu_result_o, bus_if.mem_ctrl_o);
      end
      stall_i = 1'b0;
      step();
      tests_run++;
      if ({bus_if.mem_valid_o, bus_if.mem_alu_result_o, bus_if.mem_ctrl_o}
          !== {1'b1, 32'h9999, 8'hE1}) begin
         tests_failed++;
         $display("FAIL stall_release: v %b res %h ctrl %h exp 1 9999 e1",
                  bus_if.mem_valid_o, bus_if.mem_alu_result_o, bus_if.mem_ctrl_o);
      end
   endtask

   task automatic test_branch();
      set_ex(1'b1, 32'h0000_0044, 8'h9F, 1'b1, 32'h0000_0040, 1'b0);
      step();
      tests_run++;
      if ({redirect_valid_o, flush_o, redirect_addr_o, bus_if.mem_valid_o,
           bus_if.mem_alu_result_o} !== {1'b1, 1'b1, 32'h40, 1'b1, 32'h44}) begin
         tests_failed++;
         $display("FAIL branch_taken: rv %b fl %b addr %h v %b res %h exp 1 1 40 1 44",
                  redirect_valid_o, flush_o, redirect_addr_o, bus_if.mem_valid_o,
                  bus_if.mem_alu_result_o);
      end
      // wrong-path instruction carrying its own branch and overflow
      set_ex(1'b1, 32'h0000_0077, 8'hA2, 1'b1, 32'h0000_0080, 1'b1);
      step();
      tests_run++;
      if ({redirect_valid_o, flush_o, bus_if.mem_valid_o} !== 3'b000 ||
          (bus_if.mem_ctrl_o & 8'hE0) !== 8'h00) begin
         tests_failed++;
         $display("FAIL branch_squash: rv %b fl %b v %b ctrl %h exp 0 0 0 flags 0",
                  redirect_valid_o, flush_o, bus_if.mem_valid_o, bus_if.mem_ctrl_o);
      end
      tests_run++;
      if ({ov_sticky_o, ov_count_o} !== 9'h000) begin
         tests_failed++;
         $display("FAIL squash_no_ov: sticky %b cnt %0d exp 0 0", ov_sticky_o, ov_count_o);
      end
      set_ex(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0);
      step();
   endtask

   task automatic test_branch_stall();
      int redirect_cycles = 0;
      set_ex(1'b1, 32'h0000_0104, 8'h9F, 1'b1, 32'h0000_0100, 1'b0);
      step();
      if (redirect_valid_o && flush_o) redirect_cycles++;
      stall_i = 1'b1;
      set_ex(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         if (redirect_valid_o && flush_o && redirect_addr_o == 32'h100) redirect_cycles++;
      end
      tests_run++;
      if (bus_if.mem_valid_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL branch_stall_mem: v %b exp 1", bus_if.mem_valid_o);
      end
      stall_i = 1'b0;
      step();
      if (redirect_valid_o || flush_o) redirect_cycles++;
      tests_run++;
      if (redirect_cycles !== 4 || redirect_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL branch_stall_len: cycles %0d rv %b exp 4 0",
                  redirect_cycles, redirect_valid_o);
      end
   endtask

   task automatic test_invalid_flags();
      set_ex(1'b0, 32'h0, 8'h0, 1'b1, 32'h0000_0200, 1'b1);
      step();
      step();
      tests_run++;
      if ({redirect_valid_o, flush_o, ov_sticky_o, ov_count_o} !== 11'h000) begin
         tests_failed++;
         $display("FAIL invalid_ignored: rv %b fl %b sticky %b cnt %0d exp 0 0 0 0",
                  redirect_valid_o, flush_o, ov_sticky_o, ov_count_o);
      end
   endtask

   task automatic test_overflow();
      ov_clr_i = 1'b1;
      step();
      ov_clr_i = 1'b0;
      set_ex(1'b1, 32'h8000_0000, 8'h83, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 9) begin
            tests_run++;
            if (ov_count_o !== 8'd10) begin
               tests_failed++;
               $display("FAIL ov_count10: got %0d exp 10", ov_count_o);
            end
         end
      end
      tests_run++;
      if ({ov_sticky_o, ov_count_o} !== {1'b1, 8'd255}) begin
         tests_failed++;
         $display("FAIL ov_saturate: sticky %b cnt %0d exp 1 255", ov_sticky_o, ov_count_o);
      end
      ov_clr_i = 1'b1;
      step();
      tests_run++;
      if ({ov_sticky_o, ov_count_o} !== {1'b1, 8'd1}) begin
         tests_failed++;
         $display("FAIL ov_clr_with_ov: sticky %b cnt %0d exp 1 1", ov_sticky_o, ov_count_o);
      end
      set_ex(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0);
      step();
      tests_run++;
      if ({ov_sticky_o, ov_count_o} !== 9'h000) begin
         tests_failed++;
         $display("FAIL ov_clr: sticky %b cnt %0d exp 0 0", ov_sticky_o, ov_count_o);
      end
      ov_clr_i = 1'b0;
      set_ex(1'b1, 32'h8000_0000, 8'h83, 1'b0, 32'h0, 1'b1);
      step();
      step();
      stall_i = 1'b1;
      step();
      tests_run++;
      if (ov_count_o !== 8'd2) begin
         tests_failed++;
         $display("FAIL ov_stall_hold: got %0d exp 2", ov_count_o);
      end
      ov_clr_i = 1'b1;
      step();
      tests_run++;
      if ({ov_sticky_o, ov_count_o} !== 9'h000) begin
         tests_failed++;
         $display("FAIL ov_clr_stalled: sticky %b cnt %0d exp 0 0", ov_sticky_o, ov_count_o);
      end
      ov_clr_i = 1'b0;
      stall_i  = 1'b0;
      set_ex(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0);
      step();
   endtask

   task automatic test_async_reset();
      set_ex(1'b1, 32'h0000_0304, 8'h9F, 1'b1, 32'h0000_0300, 1'b1);
      step();
      set_ex(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0);
      tests_run++;
      if (redirect_valid_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL areset_pre: rv %b exp 1", redirect_valid_o);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({redirect_valid_o, flush_o, redirect_addr_o, bus_if.mem_valid_o,
           bus_if.mem_alu_result_o, bus_if.mem_ctrl_o, ov_sticky_o, ov_count_o} !== '0) begin
         tests_failed++;
         $display("FAIL areset_async: rv %b fl %b addr %h v %b res %h ctrl %h st %b cnt %0d exp 0",
                  redirect_valid_o, flush_o, redirect_addr_o, bus_if.mem_valid_o,
                  bus_if.mem_alu_result_o, bus_if.mem_ctrl_o, ov_sticky_o, ov_count_o);
      end
      #2 rst_n = 1'b1;
      step();
      tests_run++;
      if ({redirect_valid_o, flush_o, bus_if.mem_valid_o} !== 3'b000) begin
         tests_failed++;
         $display("FAIL areset_release: rv %b fl %b v %b exp 0 0 0",
                  redirect_valid_o, flush_o, bus_if.mem_valid_o);
      end
      set_ex(1'b1, 32'h0000_0009, 8'h21, 1'b0, 32'h0, 1'b0);
      step();
      tests_run++;
      if ({bus_if.mem_valid_o, bus_if.mem_alu_result_o, redirect_valid_o}
          !== {1'b1, 32'h9, 1'b0}) begin
         tests_failed++;
         $display("FAIL areset_idle_accept: v %b res %h rv %b exp 1 9 0",
                  bus_if.mem_valid_o, bus_if.mem_alu_result_o, redirect_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_alu_capture();
      test_stall_hold();
      test_branch();
      test_branch_stall();
      test_invalid_flags();
      test_overflow();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_ex_mem_stage

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter OV_CNT_W, default 8, width of the saturating overflow event counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  memory stage busy; hold all stage state.
REQ-005 ov_clr_i  input  1  clear sticky overflow flag and counter.
REQ-006 ex_valid_i  input  1  EX slot holds a real instruction.
REQ-007 ex_alu_result_i  input  32 (RegBus)  ALU result.
REQ-008 ex_overflow_i  input  1  ALU overflow (SVA/SVS).
REQ-009 ex_branch_true_i  input  1  ALU branch/jump taken.
REQ-010 ex_new_addr_i  input  InstAddrBus  ALU branch target.
REQ-011 ex_ctrl_i  input  8  {wreg, mem_read, mem_write, rd_addr[4:0]}.
REQ-012 ex_store_data_i  input  32  store data.
REQ-013 mem_valid_o  output  1  MEM slot valid.
REQ-014 mem_alu_result_o  output  32  registered result / memory address.
REQ-015 mem_ctrl_o  output  8  registered ex_ctrl_i.
REQ-016 mem_store_data_o  output  32  registered store data.
REQ-017 redirect_valid_o  output  1  fetch redirect request.
REQ-018 redirect_addr_o  output  InstAddrBus  redirect target.
REQ-019 flush_o  output  1  kill IF/ID and ID/EX contents.
REQ-020 ov_sticky_o  output  1  sticky overflow status.
REQ-021 ov_count_o  output  OV_CNT_W  saturating count of accepted overflows.

Function
REQ-022 Accept = ex_valid_i & !stall_i & state==IDLE; on accept capture all ex_* payload into mem_* one cycle later (latency 1).
REQ-023 stall_i=1 SHALL hold every register (payload, state, redirect, counters except ov_clr_i) unchanged.
REQ-024 When not stalled and not accepting, mem_valid_o SHALL go 0 (bubble); payload registers MAY hold old values; mem_ctrl_o wreg/mem_read/mem_write SHALL be forced 0 with the bubble.
REQ-025 FSM states IDLE, REDIRECT; IDLE->REDIRECT on accept with ex_branch_true_i=1; REDIRECT->IDLE when stall_i=0; no other transitions.
REQ-026 On IDLE->REDIRECT, redirect_addr_o SHALL latch ex_new_addr_i; redirect_valid_o and flush_o SHALL equal (state==REDIRECT), registered, held through stalls.
REQ-027 In REDIRECT, incoming ex_valid_i (wrong path) SHALL be squashed: no capture, no redirect, no overflow count, even if branch_true or overflow asserted.
REQ-028 ex_branch_true_i, ex_overflow_i SHALL be ignored when ex_valid_i=0 (ALU holds stale values).
REQ-029 Taken branch itself SHALL still propagate to MEM (mem_valid_o=1) so link writes complete.
REQ-030 Accepted ex_overflow_i=1 SHALL set ov_sticky_o and increment ov_count_o, saturating at 2^OV_CNT_W-1 (no wrap).
REQ-031 ov_clr_i with simultaneous accepted overflow: result sticky=1, count=1; ov_clr_i acts even while stalled.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE and all outputs 0 (redirect_addr_o, payload, counters included), independent of clk.
REQ-033 Branch in flight at reset SHALL be dropped; first cycle after release behaves as IDLE with no redirect.

Structure
REQ-034 State enum and ctrl field positions SHALL live in shared package pipe_pkg; widths come from port_define.sv (RegBus, InstAddrBus).
REQ-035 Redirect FSM SHALL be a sub-module branch_redirect_ctrl (inputs accept/branch/target/stall; outputs redirect, flush, squash).

Verification
REQ-036 ALU add result 0x0000_0005, ctrl 0x83, valid -> next cycle mem_alu_result_o=5, mem_ctrl_o=0x83, mem_valid_o=1.
REQ-037 Taken branch target 0x40 -> next cycle redirect_valid_o=1, flush_o=1, addr 0x40 for one cycle; following EX instruction dropped (mem_valid_o=0).
REQ-038 Taken branch then stall_i=1 for 3 cycles -> redirect/flush held 4 cycles total, then IDLE.
REQ-039 Overflow on 300 accepted SVA ops with OV_CNT_W=8 -> ov_count_o=255, ov_sticky_o=1; ov_clr_i plus overflow same cycle -> count 1.
REQ-040 rst_n low mid-REDIRECT -> outputs 0 asynchronously; after release no redirect; ex_valid_i=0 with branch_true=1 -> no redirect.
